// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU operation codes, forwarding
// selects and destination-register selects.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    NO_CORTO  = 2'b00,
    CORTO_WB  = 2'b01,
    CORTO_MEM = 2'b10
  } corto_e;

  typedef enum logic [1:0] {
    DST_RT  = 2'b00,
    DST_RD  = 2'b01,
    DST_R31 = 2'b10
  } reg_dst_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU of the execute stage; shifts act on operand B and any
// unassigned operation code yields zero.
module alu
  import mips_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 4
) (
  input  logic [NB_ALU_OP-1:0] i_op,
  input  logic [NB_DATA-1:0]   i_a,
  input  logic [NB_DATA-1:0]   i_b,
  input  logic [4:0]           i_shamt,
  output logic [NB_DATA-1:0]   o_result
);

  logic signedLess;
  logic unsignedLess;

  assign signedLess   = $signed(i_a) < $signed(i_b);
  assign unsignedLess = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(NB_DATA-1){1'b0}}, signedLess};
      ALU_SLTU: o_result = {{(NB_DATA-1){1'b0}}, unsignedLess};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_shamt);
      ALU_LUI:  o_result = i_b << 16;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/etapa_ex.sv
// Execute stage: forwards rs/rt, runs the ALU, picks the destination index
// and latches everything into the EX/MEM pipeline register.
module etapa_ex
  import mips_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_ALU_OP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic [4:0]           i_shamt,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic                 i_alu_src,
  input  logic                 i_shift_var,
  input  logic [1:0]           i_reg_dst,
  input  logic                 i_link,
  input  logic [NB_DATA-1:0]   i_pc_plus8,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_write_reg,
  input  logic [1:0]           i_mem_width,
  input  logic [1:0]           i_corto_rs,
  input  logic [1:0]           i_corto_rt,
  input  logic [NB_DATA-1:0]   i_dato_MEM,
  input  logic [NB_DATA-1:0]   i_dato_WB,
  output logic [NB_DATA-1:0]   o_alu_result,
  output logic [NB_DATA-1:0]   o_store_data,
  output logic [NB_REG-1:0]    o_rd_MEM,
  output logic                 o_write_reg_MEM,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [1:0]           o_mem_width
);

  logic [NB_DATA-1:0] rsFwd, rtFwd, operandB, aluOut;
  logic [4:0]         shiftAmt;

  logic [NB_DATA-1:0] result_d, result_q;
  logic [NB_DATA-1:0] store_d, store_q;
  logic [NB_REG-1:0]  rd_d, rd_q;
  logic               writeReg_q, memRead_q, memWrite_q;
  logic [1:0]         memWidth_q;

  // Select code 11 is unused and falls back to the ID/EX value.
  always_comb begin
    rsFwd = i_rs_data;
    case (i_corto_rs)
      CORTO_WB:  rsFwd = i_dato_WB;
      CORTO_MEM: rsFwd = i_dato_MEM;
      default:   rsFwd = i_rs_data;
    endcase
    rtFwd = i_rt_data;
    case (i_corto_rt)
      CORTO_WB:  rtFwd = i_dato_WB;
      CORTO_MEM: rtFwd = i_dato_MEM;
      default:   rtFwd = i_rt_data;
    endcase
  end

  assign operandB = i_alu_src ? i_imm : rtFwd;
  assign shiftAmt = i_shift_var ? rsFwd[4:0] : i_shamt;

  alu #(
    .NB_DATA   (NB_DATA),
    .NB_ALU_OP (NB_ALU_OP)
  ) u_alu (
    .i_op     (i_alu_op),
    .i_a      (rsFwd),
    .i_b      (operandB),
    .i_shamt  (shiftAmt),
    .o_result (aluOut)
  );

  always_comb begin
    result_d = i_link ? i_pc_plus8 : aluOut;
    store_d  = rtFwd;
    rd_d     = i_rt;
    case (i_reg_dst)
      DST_RD:  rd_d = i_rd;
      DST_R31: rd_d = {NB_REG{1'b1}};
      default: rd_d = i_rt;
    endcase
  end

  // A flushed entry clears write_reg so it can never feed forwarding.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || i_flush) begin
      result_q   <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      writeReg_q <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memWidth_q <= 2'b00;
    end else if (i_enable) begin
      result_q   <= result_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      writeReg_q <= i_write_reg;
      memRead_q  <= i_mem_read;
      memWrite_q <= i_mem_write;
      memWidth_q <= i_mem_width;
    end
  end

  assign o_alu_result    = result_q;
  assign o_store_data    = store_q;
  assign o_rd_MEM        = rd_q;
  assign o_write_reg_MEM = writeReg_q;
  assign o_mem_read      = memRead_q;
  assign o_mem_write     = memWrite_q;
  assign o_mem_width     = memWidth_q;

endmodule
